// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and step modes for the mult/div sequencer
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_t;

    function automatic logic is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - issue/result bundle between the pipeline (master) and the mult/div sequencer (slave)
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             hilo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (
        output start, op, abort, a, b,
        input  busy, done, hilo_we, hi, lo, dz
    );

    modport slave (
        input  start, op, abort, a, b,
        output busy, done, hilo_we, hi, lo, dz
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  step_mode_t         mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial    = shifted - {1'b0, opnd};
        q_bit    = 1'b0;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (mode == STEP_DIV) begin
            // No borrow out of the trial subtract means the divisor fits.
            q_bit    = ~trial[WIDTH];
            acc_next = {(q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MIPS mult/multu/div/divu sequencer driving HI/LO and a PC stall
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    muldiv_if.slave   bus
);
    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic               a_neg_q, a_neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;

    logic               a_neg_in, b_neg_in;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q_bit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    step_mode_t         step_mode;

    assign step_mode = is_div(op_q) ? STEP_DIV : STEP_MUL;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (step_mode),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_acc),
        .q_bit    (step_q_bit)
    );

    always_comb begin
        a_neg_in = is_signed_op(bus.op) & bus.a[WIDTH-1];
        b_neg_in = is_signed_op(bus.op) & bus.b[WIDTH-1];
        // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
        a_abs    = a_neg_in ? (~bus.a + 1'b1) : bus.a;
        b_abs    = b_neg_in ? (~bus.b + 1'b1) : bus.b;
        prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot     = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem      = a_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        a_neg_d = a_neg_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_d    = bus.op;
                        neg_d   = a_neg_in ^ b_neg_in;
                        a_neg_d = a_neg_in;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        if (is_div(bus.op) && (bus.b == '0)) begin
                            hi_d    = bus.a;
                            lo_d    = '1;
                            dz_d    = 1'b1;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            opnd_d  = is_div(bus.op) ? b_abs : a_abs;
                            acc_d   = {{WIDTH{1'b0}}, (is_div(bus.op) ? a_abs : b_abs)};
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q_bit};
                    if (cnt_q == '0) begin
                        state_d = FIXUP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FIXUP: begin
                    if (is_div(op_q)) begin
                        hi_d = rem;
                        lo_d = quot;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            a_neg_q <= a_neg_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    // The issue-cycle term stalls the PC before the FSM has left IDLE.
    assign bus.busy    = ((state_q == IDLE) & bus.start & ~bus.abort)
                       | (state_q == CALC) | (state_q == FIXUP);
    assign bus.done    = done_q;
    assign bus.hilo_we = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.dz      = dz_q;
endmodule
